// File: rtl/seq_borrow_subtractor.sv
// Multi-cycle ripple-borrow subtractor: diff = a - b - bin.
// One CHUNK_WIDTH slice is subtracted per cycle, LSB slice first, and the
// borrow between slices is held in a register. This keeps the critical path
// at one CHUNK_WIDTH+1 bit subtract. Valid/ready handshakes are used on both
// the operand side and the result side.
module seq_borrow_subtractor #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] diff,
    output logic                  bout,
    output logic                  ovf
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
    localparam int TOP_SHIFT  = DATA_WIDTH - CHUNK_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic                    borrow;
    logic [IDX_W-1:0]        idx;
    logic [CHUNK_WIDTH:0]    chunk_res;
    logic                    diff_msb;
    logic                    a_msb;
    logic                    b_msb;

    // Unsigned CHUNK_WIDTH+1 bit subtract. The top bit of the result is set
    // exactly when x - y - br is negative, so it is the borrow-out.
    function automatic logic [CHUNK_WIDTH:0] sub_chunk(
        input logic [CHUNK_WIDTH-1:0] x,
        input logic [CHUNK_WIDTH-1:0] y,
        input logic                   br
    );
        return {1'b0, x} - {1'b0, y} - {{CHUNK_WIDTH{1'b0}}, br};
    endfunction

    // The latched operands shift right after every slice. The slice in work
    // therefore always sits in the low CHUNK_WIDTH bits. On the last slice
    // those low bits hold the operands' sign bits.
    assign chunk_res = sub_chunk(a_q[CHUNK_WIDTH-1:0], b_q[CHUNK_WIDTH-1:0], borrow);
    assign a_msb     = a_q[CHUNK_WIDTH-1];
    assign b_msb     = b_q[CHUNK_WIDTH-1];
    assign diff_msb  = chunk_res[CHUNK_WIDTH-1];

    // Operands are accepted only in IDLE. Reset forces in_ready low
    // immediately.
    assign in_ready = (state == IDLE) && !rst;

    // Control FSM and datapath. Each result slice is shifted into diff from
    // the top. After NUM_CHUNKS slices, slice 0 has reached the LSB end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            idx       <= '0;
            borrow    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        borrow <= bin;
                        idx    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    diff   <= (diff >> CHUNK_WIDTH)
                            | (DATA_WIDTH'(chunk_res[CHUNK_WIDTH-1:0]) << TOP_SHIFT);
                    borrow <= chunk_res[CHUNK_WIDTH];
                    a_q    <= a_q >> CHUNK_WIDTH;
                    b_q    <= b_q >> CHUNK_WIDTH;
                    idx    <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        bout      <= chunk_res[CHUNK_WIDTH];
                        ovf       <= (a_msb != b_msb) && (diff_msb != a_msb);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
